// File: rtl/aes_result_display.sv
// aes_result_display: captures one AES result word with its expected value,
// scrolls the word byte by byte onto six active-low 7-segment digits
// (hex or decimal), then shows a PASS/FAIL banner.
module aes_result_display #(
    parameter int DATA_W       = 128,
    parameter int DWELL_CYCLES = 50000000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              res_valid,
    output logic              res_ready,
    input  logic [DATA_W-1:0] res_data,
    input  logic [DATA_W-1:0] exp_data,
    input  logic              hex_mode,
    input  logic              hold,
    output logic              match,
    output logic              busy,
    output logic [7:0]        byte_idx,
    output logic [6:0]        HEX0,
    output logic [6:0]        HEX1,
    output logic [6:0]        HEX2,
    output logic [6:0]        HEX3,
    output logic [6:0]        HEX4,
    output logic [6:0]        HEX5
);

    localparam int NBYTES = DATA_W / 8;
    localparam int DW_W   = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1;
    localparam logic [DW_W-1:0] DWELL_LAST = DW_W'(DWELL_CYCLES - 1);
    localparam logic [7:0]      LAST_BYTE  = 8'(NBYTES - 1);

    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_P     = 7'b0001100;
    localparam logic [6:0] SEG_A     = 7'b0001000;
    localparam logic [6:0] SEG_S     = 7'b0010010;
    localparam logic [6:0] SEG_F     = 7'b0001110;
    localparam logic [6:0] SEG_I     = 7'b1111001;
    localparam logic [6:0] SEG_L     = 7'b1000111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SHOW = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state_q;
    logic [DW_W-1:0]   dwell_q;
    logic [7:0]        byte_idx_q;
    logic              match_q;
    logic              busy_q;
    logic [DATA_W-1:0] data_q;
    logic [7:0]        cur_byte;
    logic [5:0][6:0]   hex_d;
    logic [5:0][6:0]   hex_q;
    logic              capture;

    // Nibble to active-low segment pattern {g,f,e,d,c,b,a}.
    function automatic logic [6:0] seg_hex(input logic [3:0] n);
        logic [6:0] s;
        case (n)
            4'h0:    s = 7'b1000000;
            4'h1:    s = 7'b1111001;
            4'h2:    s = 7'b0100100;
            4'h3:    s = 7'b0110000;
            4'h4:    s = 7'b0011001;
            4'h5:    s = 7'b0010010;
            4'h6:    s = 7'b0000010;
            4'h7:    s = 7'b1111000;
            4'h8:    s = 7'b0000000;
            4'h9:    s = 7'b0010000;
            4'hA:    s = 7'b0001000;
            4'hB:    s = 7'b0000011;
            4'hC:    s = 7'b1000110;
            4'hD:    s = 7'b0100001;
            4'hE:    s = 7'b0000110;
            default: s = 7'b0001110;
        endcase
        return s;
    endfunction

    // Shift-and-add-3 conversion of a byte into three BCD digits.
    function automatic logic [11:0] bin2bcd(input logic [7:0] b);
        logic [19:0] s;
        s = {12'd0, b};
        for (int i = 0; i < 8; i++) begin
            if (s[11:8]  >= 4'd5) s[11:8]  = s[11:8]  + 4'd3;
            if (s[15:12] >= 4'd5) s[15:12] = s[15:12] + 4'd3;
            if (s[19:16] >= 4'd5) s[19:16] = s[19:16] + 4'd3;
            s = s << 1;
        end
        return s[19:8];
    endfunction

    // A word can only be taken when no scroll is in progress.
    assign res_ready = (state_q != SHOW);
    assign capture   = res_valid & res_ready;

    // Sequencer: capture, per-byte dwell counting with hold, and completion.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            dwell_q    <= '0;
            byte_idx_q <= '0;
            match_q    <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    if (capture) begin
                        state_q    <= SHOW;
                        dwell_q    <= '0;
                        byte_idx_q <= '0;
                        match_q    <= (res_data == exp_data);
                        busy_q     <= 1'b1;
                    end
                end
                SHOW: begin
                    // hold takes priority over the terminal count
                    if (!hold) begin
                        if (dwell_q == DWELL_LAST) begin
                            dwell_q <= '0;
                            if (byte_idx_q == LAST_BYTE) begin
                                state_q <= DONE;
                                busy_q  <= 1'b0;
                            end else begin
                                byte_idx_q <= byte_idx_q + 8'd1;
                            end
                        end else begin
                            dwell_q <= dwell_q + DW_W'(1);
                        end
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    // Result word storage; only meaningful outside IDLE, so it needs no reset.
    always_ff @(posedge clk) begin
        if (capture) data_q <= res_data;
    end

    // Select the byte currently being displayed.
    always_comb begin
        cur_byte = '0;
        for (int i = 0; i < NBYTES; i++) begin
            if (byte_idx_q == 8'(i)) cur_byte = data_q[i*8 +: 8];
        end
    end

    // Next display contents from state, byte index and display mode.
    always_comb begin
        logic [11:0] bcd;
        hex_d = {6{SEG_BLANK}};
        bcd   = bin2bcd(cur_byte);
        case (state_q)
            SHOW: begin
                hex_d[5] = seg_hex(byte_idx_q[7:4]);
                hex_d[4] = seg_hex(byte_idx_q[3:0]);
                if (hex_mode) begin
                    hex_d[1] = seg_hex(cur_byte[7:4]);
                    hex_d[0] = seg_hex(cur_byte[3:0]);
                end else begin
                    hex_d[2] = seg_hex(bcd[11:8]);
                    hex_d[1] = seg_hex(bcd[7:4]);
                    hex_d[0] = seg_hex(bcd[3:0]);
                end
            end
            DONE: begin
                if (match_q) begin
                    hex_d[3] = SEG_P;
                    hex_d[2] = SEG_A;
                    hex_d[1] = SEG_S;
                    hex_d[0] = SEG_S;
                end else begin
                    hex_d[3] = SEG_F;
                    hex_d[2] = SEG_A;
                    hex_d[1] = SEG_I;
                    hex_d[0] = SEG_L;
                end
            end
            default: hex_d = {6{SEG_BLANK}};
        endcase
    end

    // Registered display outputs, blank on reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) hex_q <= {6{SEG_BLANK}};
        else       hex_q <= hex_d;
    end

    assign match    = match_q;
    assign busy     = busy_q;
    assign byte_idx = byte_idx_q;
    assign HEX0     = hex_q[0];
    assign HEX1     = hex_q[1];
    assign HEX2     = hex_q[2];
    assign HEX3     = hex_q[3];
    assign HEX4     = hex_q[4];
    assign HEX5     = hex_q[5];

endmodule

// File: tb/tb_aes_result_display.sv
// Directed bench for aes_result_display with DATA_W=128, DWELL_CYCLES=4.
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_aes_result_display;

    localparam int DATA_W = 128;
    localparam int DWELL  = 4;

    localparam logic [6:0] G0 = 7'b1000000, G1 = 7'b1111001, G2 = 7'b0100100,
                           G3 = 7'b0110000, G5 = 7'b0010010, G6 = 7'b0000010,
                           G7 = 7'b1111000, G9 = 7'b0010000;
    localparam logic [6:0] GA = 7'b0001000, GC = 7'b1000110, GF = 7'b0001110,
                           GP = 7'b0001100, GS = 7'b0010010, GI = 7'b1111001,
                           GL = 7'b1000111, BL = 7'b1111111;

    localparam logic [127:0] K = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

    logic              clk = 1'b0;
    logic              reset;
    logic              res_valid;
    logic              res_ready;
    logic [DATA_W-1:0] res_data;
    logic [DATA_W-1:0] exp_data;
    logic              hex_mode;
    logic              hold;
    logic              match;
    logic              busy;
    logic [7:0]        byte_idx;
    logic [6:0]        HEX0, HEX1, HEX2, HEX3, HEX4, HEX5;

    int n_checks = 0;
    int n_fail   = 0;

    aes_result_display #(.DATA_W(DATA_W), .DWELL_CYCLES(DWELL)) dut (
        .clk(clk), .reset(reset), .res_valid(res_valid), .res_ready(res_ready),
        .res_data(res_data), .exp_data(exp_data), .hex_mode(hex_mode), .hold(hold),
        .match(match), .busy(busy), .byte_idx(byte_idx),
        .HEX0(HEX0), .HEX1(HEX1), .HEX2(HEX2), .HEX3(HEX3), .HEX4(HEX4), .HEX5(HEX5)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s got=%h want=%h", tag, got, want);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    function automatic logic [41:0] hexes();
        return {HEX5, HEX4, HEX3, HEX2, HEX1, HEX0};
    endfunction

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b1; res_valid = 1'b0; res_data = '0; exp_data = '0;
        hex_mode = 1'b1; hold = 1'b0;
        cyc(2);
        chk("rst_hex",   hexes(), {6{BL}});
        chk("rst_match", match, 0);
        chk("rst_busy",  busy, 0);
        chk("rst_idx",   byte_idx, 0);
        chk("rst_ready", res_ready, 1);
        reset = 1'b0;
        cyc(1);

        // Matching word, hex display
        res_data = K; exp_data = K; hex_mode = 1'b1; res_valid = 1'b1;
        cyc(1); res_valid = 1'b0;
        chk("t1_match", match, 1);
        chk("t1_busy",  busy, 1);
        chk("t1_ready", res_ready, 0);
        chk("t1_idx0",  byte_idx, 0);
        cyc(1);
        chk("t1_b0_hex", hexes(), {G0, G0, BL, BL, G5, GA});
        cyc(2);
        chk("t1_idx_n3", byte_idx, 0);
        cyc(1);
        chk("t1_idx_n4", byte_idx, 1);
        // valid pulse during SHOW must be ignored
        res_data = '0; res_valid = 1'b1;
        cyc(1); res_valid = 1'b0; res_data = K;
        chk("t1_ready_show", res_ready, 0);
        chk("t1_b1_hex", hexes(), {G0, G1, BL, BL, GC, G5});
        chk("t1_match_kept", match, 1);
        cyc(58);
        chk("t1_busy_n63", busy, 1);
        chk("t1_idx_n63",  byte_idx, 15);
        cyc(1);
        chk("t1_busy_done",  busy, 0);
        chk("t1_ready_done", res_ready, 1);
        chk("t1_idx_done",   byte_idx, 15);
        cyc(1);
        chk("t1_pass", hexes(), {BL, BL, GP, GA, GS, GS});

        // Recapture from DONE, decimal display
        hex_mode = 1'b0; res_valid = 1'b1;
        cyc(1); res_valid = 1'b0;
        chk("t2_busy", busy, 1);
        chk("t2_idx0", byte_idx, 0);
        cyc(1);
        chk("t2_dec090", hexes(), {G0, G0, BL, G0, G9, G0});
        cyc(4);
        chk("t2_dec197", hexes(), {G0, G1, BL, G1, G9, G7});
        cyc(23);
        chk("t2_idx7", byte_idx, 7);
        cyc(1);
        chk("t2_dec216", hexes(), {G0, G7, BL, G2, G1, G6});
        // asynchronous reset mid-scroll
        reset = 1'b1;
        #1;
        chk("t2_rst_hex",   hexes(), {6{BL}});
        chk("t2_rst_match", match, 0);
        chk("t2_rst_busy",  busy, 0);
        chk("t2_rst_idx",   byte_idx, 0);
        chk("t2_rst_ready", res_ready, 1);
        cyc(1); reset = 1'b0;
        cyc(1);
        chk("t2_idle_hex", hexes(), {6{BL}});

        // Mismatch in bit 127, with hold during byte 3
        res_data = K; exp_data = K ^ {1'b1, 127'd0}; hex_mode = 1'b1; res_valid = 1'b1;
        cyc(1); res_valid = 1'b0;
        chk("t3_match", match, 0);
        chk("t3_busy",  busy, 1);
        cyc(14);
        chk("t3_idx_hold_start", byte_idx, 3);
        hold = 1'b1;
        cyc(2);
        chk("t3_idx_hold2", byte_idx, 3);
        cyc(4);
        chk("t3_b3_hex", hexes(), {G0, G3, BL, BL, G7, G0});
        cyc(4);
        chk("t3_idx_hold10", byte_idx, 3);
        hold = 1'b0;
        cyc(1);
        chk("t3_idx_rel1", byte_idx, 3);
        cyc(1);
        chk("t3_idx_rel2", byte_idx, 4);
        cyc(47);
        chk("t3_busy_n73", busy, 1);
        cyc(1);
        chk("t3_busy_done",  busy, 0);
        chk("t3_match_done", match, 0);
        cyc(1);
        chk("t3_fail_banner", hexes(), {BL, BL, GF, GA, GI, GL});

        // Byte 0xff in decimal, then switch to hex
        res_data = 128'hff; exp_data = 128'hff; hex_mode = 1'b0; res_valid = 1'b1;
        cyc(1); res_valid = 1'b0;
        chk("t4_match", match, 1);
        cyc(1);
        chk("t4_dec255", hexes(), {G0, G0, BL, G2, G5, G5});
        hex_mode = 1'b1;
        cyc(1);
        chk("t4_hexff", hexes(), {G0, G0, BL, BL, GF, GF});

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/aes_result_display.md
Name: aes_result_display

Overview:
Parametrised result-readout sequencer for the AES cipher/decipher datapaths. It accepts one DATA_W-bit result word plus its expected value over a valid/ready handshake and registers a pass/fail flag. It then steps through the word one byte at a time on six active-low 7-segment digits (hex or decimal), finishing with a PASS/FAIL banner. It sits between the cipher/decipher outputs and the board HEX displays.

Parameters:
DATA_W, 128, result width in bits; multiple of 8, range 8..2048; NBYTES = DATA_W/8.
DWELL_CYCLES, 50000000, clock cycles each byte stays displayed; must be >= 1.

Ports:
clk  in  1  single clock, rising edge.
reset  in  1  asynchronous, active-high reset.
res_valid  in  1  producer has a result word.
res_ready  out  1  block can accept a word.
res_data  in  DATA_W  result word.
exp_data  in  DATA_W  expected word.
hex_mode  in  1  1 = hex byte display, 0 = decimal (0..255).
hold  in  1  freezes dwell counting while high.
match  out  1  registered (res_data == exp_data) of the last captured word.
busy  out  1  high while bytes are being scrolled.
byte_idx  out  8  index of the displayed byte (0 = res_data[7:0]).
HEX0..HEX5  out  7 each  active-low segments {g,f,e,d,c,b,a}.

Behaviour:
- Reset (async, active-high): state=IDLE; match=0, busy=0, byte_idx=0, dwell counter=0; all HEX=7'b1111111. res_ready=1 while in IDLE. Captures are ignored while reset is asserted.
- States: IDLE, SHOW, DONE.
- res_ready is combinational: 1 in IDLE and DONE, 0 in SHOW.
- A capture occurs on a rising edge with res_valid & res_ready. At that edge:
  - res_data is stored.
  - match <= (res_data == exp_data).
  - byte_idx <= 0, dwell <= 0, state <= SHOW.
- res_valid during SHOW is ignored; the producer holds it until accepted.
- SHOW:
  - busy=1.
  - Each cycle with hold=0, dwell increments.
  - At dwell == DWELL_CYCLES-1 with hold=0, dwell <= 0 and byte_idx increments. If byte_idx == NBYTES-1, go to DONE instead (byte_idx holds NBYTES-1).
  - When hold and terminal count coincide, hold wins.
  - DWELL_CYCLES=1 advances one byte per cycle.
- DONE:
  - busy=0; match held.
  - A new capture restarts SHOW from byte 0, with the same-edge transition rules as from IDLE.
- Display, all HEX registered, updating one cycle after state/byte_idx/hex_mode change:
  - IDLE: all blank.
  - SHOW, hex_mode=1: HEX1=high nibble, HEX0=low nibble, HEX2 blank.
  - SHOW, hex_mode=0: HEX2/HEX1/HEX0 = hundreds/tens/units. Leading zeros are shown.
  - SHOW, both modes: HEX5/HEX4 = byte_idx high/low nibble in hex.
  - DONE: HEX3..HEX0 = "PASS" if match, else "FAIL"; HEX5, HEX4 blank.
- Glyphs:
  - Digits 0-9: 1000000, 1111001, 0100100, 0110000, 0011001, 0010010, 0000010, 1111000, 0000000, 0010000.
  - Letters: A 0001000, b 0000011, C 1000110, d 0100001, E 0000110, F 0001110, P 0001100, S 0010010, I 1111001, L 1000111.
  - Blank 1111111.
- Binary-to-decimal conversion is combinational, covering the full 0..255 range.
- Reset asserted mid-SHOW immediately returns the block to reset values; the captured word is discarded.

Test Plan:
- Common setup: DATA_W=128, DWELL_CYCLES=4.
- Reset pulse -> HEX0..HEX5=1111111, match=0, busy=0, byte_idx=0, res_ready=1.
- Capture res_data=exp_data=128'h69c4e0d86a7b0430d8cdb78070b4c55a, hex_mode=1:
  - match=1, busy=1 after the edge.
  - Next cycle: HEX1=0010010 ('5'), HEX0=0001000 ('A'), HEX5=HEX4=1000000.
  - Byte_idx=1 (0xc5) after 4 cycles.
  - DONE after 64 cycles with HEX3..HEX0 = P,A,S,S.
- hex_mode=0, byte 0x5a -> HEX2/1/0 = 1000000, 0010000, 1000000 (090). Byte 0xff -> 0100100, 0010010, 0010010 (255).
- exp_data differs only in bit 127 -> match=0; after 64 cycles HEX3..HEX0 = F,A,I,L.
- Hold asserted for 10 cycles at dwell=2 of byte 3 -> byte_idx stays 3 during hold; advances 2 cycles after release.
- res_valid pulsed during SHOW -> no capture (res_ready=0), sequence unchanged.
- Reset asserted at byte_idx=7 -> outputs blank immediately, state IDLE, match=0.
